uart_rx_sample_ctrl: RTL and testbench
======================================

# uart_rx_sample_ctrl

UART receive sampling controller. It generates the oversampling tick from the system clock, detects the start bit, and schedules mid-bit sample strobes across start, data, parity and stop bits. It assembles the received word and reports parity and framing status. It sits between the raw `rx` pin and the receive FIFO, and replaces ad-hoc gating of the oversampling clock with a single-clock-domain strobe scheme.

## Interface
Parameters:
- `DATA_W`, 8, data bits per frame (5..9)
- `DIV_W`, 16, width of baud divisor

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `en`  in  1  block enable; 0 forces idle and clears counters
- `div`  in  DIV_W  oversample tick period minus 1, in clk cycles
- `prescale`  in  6  oversampling ratio; 8, 16 or 32; any other value is treated as 16
- `par_en`  in  1  parity bit present
- `par_odd`  in  1  1 = odd parity, 0 = even
- `rx`  in  1  asynchronous serial input, idle high
- `os_tick`  out  1  one-cycle oversample tick
- `samp_stb`  out  1  one-cycle strobe, one per sampled bit
- `bit_idx`  out  4  current data bit index
- `busy`  out  1  frame in progress (state != IDLE)
- `data_out`  out  DATA_W  last received word, LSB first on line
- `data_vld`  out  1  one-cycle pulse; `data_out`/`par_err`/`stop_err` valid
- `par_err`  out  1  parity mismatch of last frame
- `stop_err`  out  1  stop bit sampled low on last frame

## Operation
- **Reset values:** all outputs 0 and state IDLE. Synchroniser flops reset to 1.
- **Input synchroniser:** `rx` passes through a 2-flop synchroniser to give `rx_s`, adding 2 cycles of latency.
- **Tick generator:**
  - `div_cnt` counts 0..`div`.
  - `os_tick` is 1 in the cycle `div_cnt == div`, and `div_cnt` then wraps to 0.
  - `div = 0` gives a tick every cycle.
  - If `div` changes so that `div_cnt >= div`, the tick fires that cycle and the counter wraps.
  - `en = 0` holds `div_cnt` at 0, with no ticks.
- **Frame-start latching:** `prescale`, `par_en` and `par_odd` are latched on the IDLE→START transition. Changes mid-frame are ignored.
- **Counters:** `os_cnt` (6 bits) increments on each `os_tick` while busy.
  - Sample point: `os_cnt == P/2`, where P is the latched ratio.
  - Bit end: `os_cnt == P-1`, after which `os_cnt` returns to 0.
- **FSM:** IDLE, START, DATA, PARITY, STOP. All transitions happen on `os_tick` cycles only.
  - **IDLE:** `rx_s == 0` → START, with `os_cnt = 0` and `bit_cnt = 0`.
  - **START:** at the sample point, `rx_s == 1` is a false start → IDLE with no flags and no `data_vld`. At bit end → DATA.
  - **DATA:** at each sample point, shift `rx_s` into the MSB of the shift register (right shift, LSB-first reception). At bit end:
    - `bit_cnt == DATA_W-1` → PARITY if `par_en`, otherwise STOP.
    - Otherwise `bit_cnt` increments.
  - **PARITY:** sample the parity bit. At bit end → STOP.
  - **STOP:** at the sample point, load `data_out`, set `stop_err = ~sample`, set `par_err` (0 when parity is disabled), and return to IDLE immediately. The half stop bit allows back-to-back frames.
- **Error flags:** `par_err` and `stop_err` hold until the next `data_vld`.
- **Output hold:** `data_out` holds until the next `data_vld`.
- **`en` dropped mid-frame:** → IDLE on the next edge. Counters are cleared, no `data_vld` is issued, and `data_out` and the flags are retained.

## Timing
- `samp_stb` is registered: it asserts the cycle after the `os_tick` on which a bit is sampled.
- `data_vld` coincides with the stop-bit `samp_stb`.
- `bit_idx` equals `bit_cnt`, registered.
- Start detection to first data-bit sample: 1.5·P ticks, plus up to 1 tick of detection jitter, plus 2 cycles for the synchroniser.
- `busy` rises the cycle after the detecting tick and falls the cycle after the stop sample.

## Configuration
- **`UART_RX_MAJORITY_EN` defined:** each bit value is the 2-of-3 majority of `rx_s` at `os_cnt` = P/2-1, P/2 and P/2+1. The decision, `samp_stb` and the STOP exit move to P/2+1. The start-bit check also uses the majority.
- **Undefined:** a single sample at P/2, as described above.

## Structure
- **Package `uart_pkg`:** FSM state enum, the constants `OS_8`, `OS_16`, `OS_32`, and the prescale-legalise function.
- **Sub-module `uart_os_tick_gen`:** the divider counter and `os_tick`. The FSM, synchroniser and shift register stay in the top level.

## Test plan
- `div = 3`, P = 16, 8N1, send 0xA5:
  - `os_tick` every 4 clk.
  - Exactly one `data_vld` with `data_out = 0xA5`, `par_err = 0`, `stop_err = 0`.
- Even parity, send 0x3C with parity bit = 1 → `data_vld` with `par_err = 1` and `data_out = 0x3C`.
- `rx` low for 3 ticks only (P = 16) → returns to IDLE, `busy` low before tick 10, no `data_vld`.
- Send 0x00 with stop bit 0 → `stop_err = 1`, `data_out = 0x00`. A following good frame 0x81 clears `stop_err`.
- Drop `en` during DATA bit 4 → `busy = 0` next cycle, no `data_vld`. After re-enable, 0x5A is received correctly.
- Two frames back-to-back at P = 8 → both received.
- 0xFF with a single-tick low glitch at the P/2 sample of bit 3:
  - With `UART_RX_MAJORITY_EN` → `data_out = 0xFF`.
  - Without it → `data_out = 0xF7`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive sampling controller.
package uart_pkg;

   localparam int unsigned OS_CNT_W = 6;

   localparam logic [OS_CNT_W-1:0] OS_8  = 6'd8;
   localparam logic [OS_CNT_W-1:0] OS_16 = 6'd16;
   localparam logic [OS_CNT_W-1:0] OS_32 = 6'd32;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_rx_state_t;

   // Unsupported oversampling ratios fall back to 16.
   function automatic logic [OS_CNT_W-1:0] prescale_legal(input logic [OS_CNT_W-1:0] p);
      case (p)
         OS_8, OS_16, OS_32: prescale_legal = p;
         default:            prescale_legal = OS_16;
      endcase
   endfunction

   function automatic logic maj3(input logic a, input logic b, input logic c);
      maj3 = (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_os_tick_gen.sv
// Oversample tick divider: os_tick fires when the counter reaches div, then wraps.
module uart_os_tick_gen #(
   parameter int unsigned DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   output logic             os_tick
);

   logic [DIV_W-1:0] r_div_cnt;
   logic             w_wrap;

   // >= so a reduced divisor still produces a tick and a clean wrap.
   assign w_wrap  = (r_div_cnt >= div);
   assign os_tick = en & w_wrap;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div_cnt <= '0;
      end else if (!en || w_wrap) begin
         r_div_cnt <= '0;
      end else begin
         r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/uart_rx_sample_ctrl.sv
// UART receive sampling controller: synchroniser, bit-sampling FSM and word assembly.
// Optional build macro UART_RX_MAJORITY_EN selects 2-of-3 majority sampling.
module uart_rx_sample_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DIV_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [DIV_W-1:0]  div,
   input  logic [5:0]        prescale,
   input  logic              par_en,
   input  logic              par_odd,
   input  logic              rx,
   output logic              os_tick,
   output logic              samp_stb,
   output logic [3:0]        bit_idx,
   output logic              busy,
   output logic [DATA_W-1:0] data_out,
   output logic              data_vld,
   output logic              par_err,
   output logic              stop_err
);

   logic r_sync1, r_sync2;
   logic w_rx_s, w_tick;

   uart_rx_state_t r_state, w_state_nxt;

   logic [OS_CNT_W-1:0] r_os_cnt, w_os_cnt_nxt;
   logic [3:0]          r_bit_cnt, w_bit_cnt_nxt;
   logic [DATA_W-1:0]   r_shift, w_shift_nxt;
   logic                r_par_bit, w_par_bit_nxt;
   logic [OS_CNT_W-1:0] r_p, w_p_nxt;
   logic                r_par_en, w_par_en_nxt;
   logic                r_par_odd, w_par_odd_nxt;

   logic                r_samp_stb, w_samp_stb_nxt;
   logic                r_data_vld, w_data_vld_nxt;
   logic                r_busy, w_busy_nxt;
   logic [DATA_W-1:0]   r_data_out, w_data_out_nxt;
   logic                r_par_err, w_par_err_nxt;
   logic                r_stop_err, w_stop_err_nxt;

   logic [OS_CNT_W-1:0] w_half, w_last;
   logic                w_dec, w_bit, w_bit_end;

   uart_os_tick_gen #(.DIV_W(DIV_W)) u_tick (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .div     (div),
      .os_tick (w_tick)
   );

   // Two-flop synchroniser, idle-high reset so no false start out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= rx;
         r_sync2 <= r_sync1;
      end
   end

   assign w_rx_s    = r_sync2;
   assign w_half    = OS_CNT_W'(r_p >> 1);
   assign w_last    = r_p - OS_CNT_W'(1);
   assign w_bit_end = w_tick && (r_os_cnt == w_last);

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] r_maj, w_maj_nxt;

   assign w_dec = w_tick && (r_os_cnt == w_half + OS_CNT_W'(1));
   assign w_bit = maj3(r_maj[0], r_maj[1], w_rx_s);

   always_comb begin
      w_maj_nxt = r_maj;
      if (w_tick && (r_os_cnt == w_half - OS_CNT_W'(1))) w_maj_nxt[0] = w_rx_s;
      if (w_tick && (r_os_cnt == w_half))                w_maj_nxt[1] = w_rx_s;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_maj <= 2'b11;
      else        r_maj <= w_maj_nxt;
   end
`else
   assign w_dec = w_tick && (r_os_cnt == w_half);
   assign w_bit = w_rx_s;
`endif

   // Next-state and next-output logic.
   always_comb begin
      w_state_nxt    = r_state;
      w_os_cnt_nxt   = r_os_cnt;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_shift_nxt    = r_shift;
      w_par_bit_nxt  = r_par_bit;
      w_p_nxt        = r_p;
      w_par_en_nxt   = r_par_en;
      w_par_odd_nxt  = r_par_odd;
      w_samp_stb_nxt = 1'b0;
      w_data_vld_nxt = 1'b0;
      w_data_out_nxt = r_data_out;
      w_par_err_nxt  = r_par_err;
      w_stop_err_nxt = r_stop_err;

      if (r_state != ST_IDLE && w_tick) begin
         w_os_cnt_nxt = w_bit_end ? '0 : r_os_cnt + OS_CNT_W'(1);
      end

      case (r_state)
         ST_IDLE: begin
            w_os_cnt_nxt = '0;
            if (w_tick && !w_rx_s) begin
               w_state_nxt   = ST_START;
               w_bit_cnt_nxt = '0;
               w_p_nxt       = prescale_legal(prescale);
               w_par_en_nxt  = par_en;
               w_par_odd_nxt = par_odd;
            end
         end
         ST_START: begin
            if (w_dec) begin
               w_samp_stb_nxt = 1'b1;
               if (w_bit) begin
                  w_state_nxt  = ST_IDLE;
                  w_os_cnt_nxt = '0;
               end
            end
            if (w_bit_end) w_state_nxt = ST_DATA;
         end
         ST_DATA: begin
            if (w_dec) begin
               w_samp_stb_nxt = 1'b1;
               w_shift_nxt    = {w_bit, r_shift[DATA_W-1:1]};
            end
            if (w_bit_end) begin
               if (r_bit_cnt == 4'(DATA_W - 1)) begin
                  w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + 4'd1;
               end
            end
         end
         ST_PARITY: begin
            if (w_dec) begin
               w_samp_stb_nxt = 1'b1;
               w_par_bit_nxt  = w_bit;
            end
            if (w_bit_end) w_state_nxt = ST_STOP;
         end
         ST_STOP: begin
            // Leave at mid stop bit so a back-to-back start edge is not missed.
            if (w_dec) begin
               w_samp_stb_nxt = 1'b1;
               w_data_vld_nxt = 1'b1;
               w_data_out_nxt = r_shift;
               w_stop_err_nxt = ~w_bit;
               w_par_err_nxt  = r_par_en & ((^r_shift) ^ r_par_bit ^ r_par_odd);
               w_state_nxt    = ST_IDLE;
               w_os_cnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt  = ST_IDLE;
            w_os_cnt_nxt = '0;
         end
      endcase

      if (!en) begin
         w_state_nxt    = ST_IDLE;
         w_os_cnt_nxt   = '0;
         w_bit_cnt_nxt  = '0;
         w_samp_stb_nxt = 1'b0;
         w_data_vld_nxt = 1'b0;
         w_data_out_nxt = r_data_out;
         w_par_err_nxt  = r_par_err;
         w_stop_err_nxt = r_stop_err;
      end

      w_busy_nxt = (w_state_nxt != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_os_cnt   <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_par_bit  <= 1'b0;
         r_p        <= OS_16;
         r_par_en   <= 1'b0;
         r_par_odd  <= 1'b0;
         r_samp_stb <= 1'b0;
         r_data_vld <= 1'b0;
         r_busy     <= 1'b0;
         r_data_out <= '0;
         r_par_err  <= 1'b0;
         r_stop_err <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_os_cnt   <= w_os_cnt_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_shift    <= w_shift_nxt;
         r_par_bit  <= w_par_bit_nxt;
         r_p        <= w_p_nxt;
         r_par_en   <= w_par_en_nxt;
         r_par_odd  <= w_par_odd_nxt;
         r_samp_stb <= w_samp_stb_nxt;
         r_data_vld <= w_data_vld_nxt;
         r_busy     <= w_busy_nxt;
         r_data_out <= w_data_out_nxt;
         r_par_err  <= w_par_err_nxt;
         r_stop_err <= w_stop_err_nxt;
      end
   end

   assign os_tick  = w_tick;
   assign samp_stb = r_samp_stb;
   assign bit_idx  = r_bit_cnt;
   assign busy     = r_busy;
   assign data_out = r_data_out;
   assign data_vld = r_data_vld;
   assign par_err  = r_par_err;
   assign stop_err = r_stop_err;

endmodule

// File: tb/tb_uart_rx_sample_ctrl.sv
// Directed bench for uart_rx_sample_ctrl; expected glitch result follows UART_RX_MAJORITY_EN.
module tb_uart_rx_sample_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [15:0] div;
   logic [5:0]  prescale;
   logic        par_en;
   logic        par_odd;
   logic        rx;
   logic        os_tick;
   logic        samp_stb;
   logic [3:0]  bit_idx;
   logic        busy;
   logic [7:0]  data_out;
   logic        data_vld;
   logic        par_err;
   logic        stop_err;

   int n_checks = 0;
   int n_fail   = 0;
   int n_vld    = 0;
   int n_stb    = 0;
   logic [7:0] vld_data [256];
   logic       vld_perr [256];
   logic       vld_serr [256];

   always #5 clk = ~clk;

   uart_rx_sample_ctrl #(.DATA_W(8), .DIV_W(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .div      (div),
      .prescale (prescale),
      .par_en   (par_en),
      .par_odd  (par_odd),
      .rx       (rx),
      .os_tick  (os_tick),
      .samp_stb (samp_stb),
      .bit_idx  (bit_idx),
      .busy     (busy),
      .data_out (data_out),
      .data_vld (data_vld),
      .par_err  (par_err),
      .stop_err (stop_err)
   );

   // Capture every completed word and count sample strobes.
   always @(negedge clk) begin
      if (rst_n) begin
         if (data_vld) begin
            vld_data[8'(n_vld)] <= data_out;
            vld_perr[8'(n_vld)] <= par_err;
            vld_serr[8'(n_vld)] <= stop_err;
            n_vld <= n_vld + 1;
         end
         if (samp_stb) n_stb <= n_stb + 1;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic wait_tick();
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!os_tick && k < 64);
      if (!os_tick) check_eq("tick_timeout", 32'(os_tick), 32'd1);
   endtask

   task automatic idle_bits(input int bits, input int pscl);
      repeat (bits * 4 * pscl) @(negedge clk);
   endtask

   // Drive one frame aligned to a tick; div is 3 so one bit lasts 4*pscl clocks.
   task automatic send_frame(input logic [7:0] d, input bit pe, input bit pbit, input bit sbit,
                             input int pscl, input int glitch_cyc, input int endrop_cyc);
      logic [11:0] line;
      int nb;
      int bclk;
      bclk = 4 * pscl;
      line = '1;
      line[0] = 1'b0;
      for (int i = 0; i < 8; i++) line[i+1] = d[i];
      nb = 9;
      if (pe) begin
         line[nb] = pbit;
         nb++;
      end
      line[nb] = sbit;
      nb++;
      wait_tick();
      for (int n = 0; n < nb * bclk; n++) begin
         rx = line[n / bclk];
         if (n == glitch_cyc) rx = 1'b0;
         if (n == endrop_cyc) begin
            check_eq("endrop_busy_before", 32'(busy), 32'd1);
            en = 1'b0;
         end
         if (n == endrop_cyc + 1) check_eq("endrop_busy_after", 32'(busy), 32'd0);
         @(negedge clk);
      end
      rx = 1'b1;
   endtask

   initial begin
      int base;
      int sb;
      int k;
      logic [7:0] exp_glitch;

      rst_n = 1'b0; en = 1'b0; rx = 1'b1; div = 16'd3;
      prescale = 6'd16; par_en = 1'b0; par_odd = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_os_tick",  32'(os_tick),  32'd0);
      check_eq("rst_samp_stb", 32'(samp_stb), 32'd0);
      check_eq("rst_bit_idx",  32'(bit_idx),  32'd0);
      check_eq("rst_busy",     32'(busy),     32'd0);
      check_eq("rst_data_out", 32'(data_out), 32'd0);
      check_eq("rst_data_vld", 32'(data_vld), 32'd0);
      check_eq("rst_par_err",  32'(par_err),  32'd0);
      check_eq("rst_stop_err", 32'(stop_err), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      en = 1'b1;

      // Tick period with div = 3
      wait_tick();
      for (int t = 0; t < 3; t++) begin
         k = 0;
         do begin
            @(negedge clk);
            k++;
         end while (!os_tick && k < 64);
         check_eq("tick_period", 32'(k), 32'd4);
      end

      // 8N1 0xA5
      base = n_vld; sb = n_stb;
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 16, -1, -1);
      idle_bits(2, 16);
      check_eq("a5_count",   32'(n_vld - base), 32'd1);
      check_eq("a5_data",    32'(vld_data[8'(base)]), 32'hA5);
      check_eq("a5_perr",    32'(vld_perr[8'(base)]), 32'd0);
      check_eq("a5_serr",    32'(vld_serr[8'(base)]), 32'd0);
      check_eq("a5_strobes", 32'(n_stb - sb), 32'd10);
      check_eq("a5_dout",    32'(data_out), 32'hA5);
      check_eq("a5_idle",    32'(busy), 32'd0);

      // Even parity, 0x3C with wrong parity bit
      par_en = 1'b1; par_odd = 1'b0;
      base = n_vld;
      send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 16, -1, -1);
      idle_bits(2, 16);
      par_en = 1'b0;
      check_eq("par_count", 32'(n_vld - base), 32'd1);
      check_eq("par_data",  32'(vld_data[8'(base)]), 32'h3C);
      check_eq("par_perr",  32'(vld_perr[8'(base)]), 32'd1);

      // False start: rx low for 3 ticks
      base = n_vld;
      wait_tick();
      for (int n = 0; n < 60; n++) begin
         rx = (n < 12) ? 1'b0 : 1'b1;
         if (n == 20) check_eq("fs_busy_hi", 32'(busy), 32'd1);
         if (n == 50) check_eq("fs_busy_lo", 32'(busy), 32'd0);
         @(negedge clk);
      end
      idle_bits(1, 16);
      check_eq("fs_count", 32'(n_vld - base), 32'd0);

      // Stop error then good frame
      base = n_vld;
      send_frame(8'h00, 1'b0, 1'b0, 1'b0, 16, -1, -1);
      idle_bits(3, 16);
      check_eq("se_count", 32'(n_vld - base), 32'd1);
      check_eq("se_data",  32'(vld_data[8'(base)]), 32'h00);
      check_eq("se_serr",  32'(vld_serr[8'(base)]), 32'd1);
      base = n_vld;
      send_frame(8'h81, 1'b0, 1'b0, 1'b1, 16, -1, -1);
      idle_bits(2, 16);
      check_eq("ok_count", 32'(n_vld - base), 32'd1);
      check_eq("ok_data",  32'(vld_data[8'(base)]), 32'h81);
      check_eq("ok_serr",  32'(stop_err), 32'd0);

      // Drop en during data bit 4
      base = n_vld;
      send_frame(8'h66, 1'b0, 1'b0, 1'b1, 16, -1, 340);
      idle_bits(1, 16);
      en = 1'b1;
      idle_bits(2, 16);
      check_eq("drop_count", 32'(n_vld - base), 32'd0);
      check_eq("drop_hold",  32'(data_out), 32'h81);
      base = n_vld;
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 16, -1, -1);
      idle_bits(2, 16);
      check_eq("reen_count", 32'(n_vld - base), 32'd1);
      check_eq("reen_data",  32'(vld_data[8'(base)]), 32'h5A);

      // Back-to-back at P = 8
      prescale = 6'd8;
      base = n_vld;
      send_frame(8'h33, 1'b0, 1'b0, 1'b1, 8, -1, -1);
      send_frame(8'hC6, 1'b0, 1'b0, 1'b1, 8, -1, -1);
      idle_bits(2, 8);
      prescale = 6'd16;
      check_eq("b2b_count", 32'(n_vld - base), 32'd2);
      check_eq("b2b_data0", 32'(vld_data[8'(base)]), 32'h33);
      check_eq("b2b_data1", 32'(vld_data[8'(base + 1)]), 32'hC6);

      // One-tick glitch on the centre sample of bit 3
`ifdef UART_RX_MAJORITY_EN
      exp_glitch = 8'hFF;
`else
      exp_glitch = 8'hF7;
`endif
      base = n_vld;
      send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 16, 294, -1);
      idle_bits(2, 16);
      check_eq("glitch_count", 32'(n_vld - base), 32'd1);
      check_eq("glitch_data",  32'(vld_data[8'(base)]), 32'(exp_glitch));

      // Unsupported prescale behaves as 16
      prescale = 6'd5;
      base = n_vld;
      send_frame(8'h96, 1'b0, 1'b0, 1'b1, 16, -1, -1);
      idle_bits(2, 16);
      check_eq("ps5_count", 32'(n_vld - base), 32'd1);
      check_eq("ps5_data",  32'(vld_data[8'(base)]), 32'h96);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
